// File: rtl/router_sync_n_if.sv
// rtl/router_sync_n_if.sv - Interface between the router FSM/FIFO side and router_sync_n
interface router_sync_n_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic [ADDR_W-1:0]    data_in;
    logic                 detect_add;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic                 timeout_en;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;

    modport master (
        output data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err
    );

    modport slave (
        input  data_in, detect_add, write_enb_reg, full, empty, read_enb, timeout_en,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err
    );
endinterface

// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - Router synchronizer: address latch, write steering, per-port stall watchdog
module router_sync_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30
) (
    input  logic            clock,
    input  logic            reset,
    router_sync_n_if.slave  bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  LP_PORTS = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0]    r_addr_q;
    logic                 r_addr_vld_q;
    logic                 r_addr_err;
    logic [CNT_W-1:0]     r_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_soft_reset;

    logic [NUM_PORTS-1:0] w_dec;
    logic                 w_sel_ok;
    logic [NUM_PORTS-1:0] w_vld;
    logic [NUM_PORTS-1:0] w_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr_q     <= '0;
            r_addr_vld_q <= 1'b0;
            r_addr_err   <= 1'b0;
        end else if (bus.detect_add) begin
            r_addr_q     <= bus.data_in;
            r_addr_vld_q <= 1'b1;
            r_addr_err   <= ({1'b0, bus.data_in} >= LP_PORTS);
        end
    end

    // Decode only the legal port indices; out-of-range addresses decode to all zero.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dec
        assign w_dec[g] = (r_addr_q == ADDR_W'(g));
    end

    assign w_sel_ok      = r_addr_vld_q && !r_addr_err;
    assign bus.write_enb = (w_sel_ok && bus.write_enb_reg) ? w_dec : '0;
    assign bus.fifo_full = w_sel_ok && |(w_dec & bus.full);
    assign bus.addr_err  = r_addr_err;

    assign w_vld       = ~bus.empty;
    assign bus.vld_out = w_vld;
    assign w_stall     = w_vld & ~bus.read_enb & {NUM_PORTS{bus.timeout_en}};

    // Any non-stall edge restarts the count, so a pulse needs TIMEOUT consecutive stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
            r_soft_reset <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_stall[i]) begin
                    r_cnt[i]        <= '0;
                    r_soft_reset[i] <= 1'b0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_cnt[i]        <= '0;
                    r_soft_reset[i] <= 1'b1;
                end else begin
                    r_cnt[i]        <= r_cnt[i] + 1'b1;
                    r_soft_reset[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.soft_reset = r_soft_reset;
endmodule
